// File: rtl/ro_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
package ro_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_GATE_W      = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // All-ones value for a w-bit saturating counter (w < 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/ro_freq_meter_if.sv
// Control/result bus of ro_freq_meter: start request in, valid/ready result out.
interface ro_freq_meter_if #(
  parameter int WIDTH  = 16,
  parameter int GATE_W = 16
);
  logic              start;
  logic [GATE_W-1:0] gate_cycles;
  logic              busy;
  logic [WIDTH-1:0]  result;
  logic              overflow;
  logic              result_valid;
  logic              result_ready;

  modport master (output start, gate_cycles, result_ready,
                  input  busy, result, overflow, result_valid);
  modport slave  (input  start, gate_cycles, result_ready,
                  output busy, result, overflow, result_valid);
endinterface

// File: rtl/ro_edge_sync.sv
// Synchronizes the raw ring-oscillator signal into clk and emits a
// one-cycle pulse per rising edge.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic edge_p
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ro_s, ro_d;

  assign ro_s   = sync_q[SYNC_STAGES-1];
  assign edge_p = ro_s & ~ro_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      ro_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      ro_d   <= ro_s;
    end
  end
endmodule

// File: rtl/ro_freq_meter.sv
// Counts ring-oscillator rising edges over a gate window of clk cycles and
// reports the count on a valid/ready bus. Option: RO_METER_CONTINUOUS_EN.
module ro_freq_meter
  import ro_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ro_in,
  ro_freq_meter_if.slave  bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_max(WIDTH));

  state_t            state, state_nxt;
  logic [GATE_W-1:0] gate_cnt;
  logic [WIDTH-1:0]  edge_cnt, cnt_nxt;
  logic              ovf_int, ovf_nxt;
  logic              edge_p, start_ok, hs, last, sat, reload;

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_in  (ro_in),
    .edge_p (edge_p)
  );

  assign start_ok = bus.start && (bus.gate_cycles != '0);
  assign hs       = bus.result_valid && bus.result_ready;
  assign last     = (gate_cnt == GATE_W'(1));
  assign sat      = (edge_cnt == CNT_MAX);
  assign cnt_nxt  = (edge_p && !sat) ? edge_cnt + WIDTH'(1) : edge_cnt;
  assign ovf_nxt  = ovf_int | (edge_p & sat);

  always_comb begin
    state_nxt = state;
    reload    = 1'b0;
    case (state)
      IDLE:    if (start_ok) begin state_nxt = MEASURE; reload = 1'b1; end
      MEASURE: if (last) state_nxt = REPORT;
      REPORT:  if (hs) begin
`ifdef RO_METER_CONTINUOUS_EN
        if (bus.gate_cycles != '0) begin
          state_nxt = MEASURE;
          reload    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.busy <= (state_nxt != IDLE);
    end
  end

  // The final cycle's edge is folded straight into the reported count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt         <= '0;
      edge_cnt         <= '0;
      ovf_int          <= 1'b0;
      bus.result       <= '0;
      bus.overflow     <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      if (reload) begin
        gate_cnt <= bus.gate_cycles;
        edge_cnt <= '0;
        ovf_int  <= 1'b0;
      end else if (state == MEASURE) begin
        gate_cnt <= gate_cnt - GATE_W'(1);
        edge_cnt <= cnt_nxt;
        ovf_int  <= ovf_nxt;
        if (last) begin
          bus.result       <= cnt_nxt;
          bus.overflow     <= ovf_nxt;
          bus.result_valid <= 1'b1;
        end
      end
      if (state == REPORT && hs) bus.result_valid <= 1'b0;
    end
  end
endmodule
